micro_sequencer: RTL
====================

# micro_sequencer

Microprogram sequencer for the MIPS microprogrammed control unit. Holds the 5-bit micro-program counter (uPC) that addresses the microcode ROM and selects its next value each cycle: fetch restart, increment, dispatch-table-1 target or dispatch-table-2 target. Consumes the 5-bit microaddresses from both dispatch tables (DT2 supplies mul → 17, madd → 22, msub → 23). Also tracks per-instruction microcycle and retired-instruction counts and flags illegal dispatches.

## Interface
- UPC_W, 5, uPC / dispatch address width
- TRAP_ADDR, 5'b11111, microaddress of the illegal-instruction handler
- CYC_W, 8, width of the per-instruction microcycle counter
- ICNT_W, 16, width of the retired-instruction counter
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- addr_ctl  input  2  sequencing field of the current microinstruction: 00 fetch, 01 dispatch 1, 10 dispatch 2, 11 next
- stall  input  1  hold uPC and counters this cycle (memory wait)
- dt1_addr  input  UPC_W  dispatch-table-1 target
- dt1_valid  input  1  dt1_addr is a decoded opcode
- dt2_addr  input  UPC_W  dispatch-table-2 target
- dt2_valid  input  1  dt2_addr is a decoded opcode/funct pair
- upc  output  UPC_W  current microaddress to the microcode ROM
- instr_done  output  1  one-cycle pulse, instruction returned to fetch
- illegal  output  1  sticky flag, an invalid dispatch occurred
- ucycle_cnt  output  CYC_W  microcycles spent in current instruction
- instr_count  output  ICNT_W  retired instructions

## Operation
- addr_ctl is read combinationally from the ROM at upc; next uPC is registered.
- Priority per edge: reset > stall > addr_ctl.
- Reset (rst_n=0 at edge): upc=0, instr_done=0, illegal=0, ucycle_cnt=0, instr_count=0. Reset asserted mid-instruction abandons it; no instr_done, no count.
- stall=1: all registers hold; instr_done=0.
- addr_ctl=11: upc←upc+1, modulo 2^UPC_W (31 wraps to 0, no flag).
- addr_ctl=01: upc←dt1_addr if dt1_valid, else upc←TRAP_ADDR and illegal←1.
- addr_ctl=10: upc←dt2_addr if dt2_valid, else upc←TRAP_ADDR and illegal←1.
- addr_ctl=00: upc←0; instr_done←1 for one cycle; instr_count←instr_count+1 (wraps); ucycle_cnt←0.
- Otherwise ucycle_cnt←ucycle_cnt+1, saturating at 2^CYC_W−1.
- illegal clears only on reset.
- Implied states: FETCH (upc=0), DECODE (after dispatch 1), EXEC (after dispatch 2 / next), TRAP (upc=TRAP_ADDR); transitions solely per addr_ctl above. No internal FSM beyond uPC.

## Timing
- Latency one cycle from addr_ctl/dispatch inputs to upc.
- instr_done, instr_count, ucycle_cnt reset all update at the same edge that loads upc=0.
- dt*_addr, dt*_valid sampled only in the cycle addr_ctl selects them; don't-care otherwise.
- Stall during a dispatch cycle: dispatch not taken, inputs re-sampled next non-stalled cycle.
- Dispatch to TRAP_ADDR with valid=1 does not set illegal.

## Test plan
- Reset: rst_n=0 two cycles with addr_ctl=11 → upc=0, all outputs 0; release → upc 1, 2, 3 on successive edges.
- mul path: sequence 11, 01 (dt1_addr=6, valid), 10 (dt2_addr=17, valid), 11, 00 → upc 1, 6, 17, 18, 0; instr_done pulses once; instr_count=1; ucycle_cnt reaches 4 then 0.
- madd/msub: addr_ctl=10 with dt2_addr=22 then in a later instruction 23 → upc 22 / 23 after one cycle.
- Illegal: addr_ctl=10, dt2_valid=0, dt2_addr=17 → upc=31, illegal=1, remains 1 after subsequent fetch.
- Stall: stall=1 for 3 cycles at upc=17 with addr_ctl=11 → upc, ucycle_cnt unchanged; then 18.
- Wrap/saturation: upc=31, addr_ctl=11 → upc=0, no instr_done; 300 consecutive 11 cycles → ucycle_cnt holds 255.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Control-side bundle between the microcode ROM / dispatch tables and the sequencer.
interface micro_sequencer_if #(
    parameter int UPC_W  = 5,
    parameter int CYC_W  = 8,
    parameter int ICNT_W = 16
);
    logic [1:0]        addr_ctl;
    logic              stall;
    logic [UPC_W-1:0]  dt1_addr;
    logic              dt1_valid;
    logic [UPC_W-1:0]  dt2_addr;
    logic              dt2_valid;
    logic [UPC_W-1:0]  upc;
    logic              instr_done;
    logic              illegal;
    logic [CYC_W-1:0]  ucycle_cnt;
    logic [ICNT_W-1:0] instr_count;

    modport master (
        output addr_ctl, stall, dt1_addr, dt1_valid, dt2_addr, dt2_valid,
        input  upc, instr_done, illegal, ucycle_cnt, instr_count
    );

    modport slave (
        input  addr_ctl, stall, dt1_addr, dt1_valid, dt2_addr, dt2_valid,
        output upc, instr_done, illegal, ucycle_cnt, instr_count
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registers the uPC and selects fetch / next / dispatch targets,
// with per-instruction microcycle count, retired-instruction count and sticky illegal flag.
module micro_sequencer #(
    parameter int               UPC_W     = 5,
    parameter logic [UPC_W-1:0] TRAP_ADDR = '1,
    parameter int               CYC_W     = 8,
    parameter int               ICNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    micro_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        CTL_FETCH = 2'b00,
        CTL_DISP1 = 2'b01,
        CTL_DISP2 = 2'b10,
        CTL_NEXT  = 2'b11
    } ctl_e;

    ctl_e              ctl;
    logic [UPC_W-1:0]  upc;
    logic              instr_done;
    logic              illegal;
    logic [CYC_W-1:0]  ucycle_cnt;
    logic [ICNT_W-1:0] instr_count;

    assign ctl = ctl_e'(bus.addr_ctl);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upc         <= '0;
            instr_done  <= 1'b0;
            illegal     <= 1'b0;
            ucycle_cnt  <= '0;
            instr_count <= '0;
        end else if (bus.stall) begin
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (ctl)
                CTL_NEXT: upc <= upc + UPC_W'(1);
                CTL_DISP1: begin
                    if (bus.dt1_valid) begin
                        upc <= bus.dt1_addr;
                    end else begin
                        upc     <= TRAP_ADDR;
                        illegal <= 1'b1;
                    end
                end
                CTL_DISP2: begin
                    if (bus.dt2_valid) begin
                        upc <= bus.dt2_addr;
                    end else begin
                        upc     <= TRAP_ADDR;
                        illegal <= 1'b1;
                    end
                end
                default: begin
                    upc         <= '0;
                    instr_done  <= 1'b1;
                    instr_count <= instr_count + ICNT_W'(1);
                end
            endcase
            // Microcycle count restarts on fetch, otherwise saturates at all-ones.
            if (ctl == CTL_FETCH) begin
                ucycle_cnt <= '0;
            end else if (ucycle_cnt != '1) begin
                ucycle_cnt <= ucycle_cnt + CYC_W'(1);
            end
        end
    end

    assign bus.upc         = upc;
    assign bus.instr_done  = instr_done;
    assign bus.illegal     = illegal;
    assign bus.ucycle_cnt  = ucycle_cnt;
    assign bus.instr_count = instr_count;
endmodule
